// File: rtl/branch_predictor_unit_if.sv
// Fetch-lookup / resolve-update bundle of the branch predictor.
// Valid/ready semantics: neither channel has backpressure; fetch_valid and resolve_valid are sampled every cycle and always accepted.
interface branch_predictor_unit_if #(
    parameter int GW = 1
);
    logic          fetch_valid;
    logic [31:0]   fetch_pc;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [GW-1:0] pred_ghr;
    logic          resolve_valid;
    logic [31:0]   resolve_pc;
    logic          resolve_taken;
    logic [31:0]   resolve_target;
    logic [31:0]   resolve_pred_pc;
    logic [GW-1:0] resolve_ghr;
    logic          flush;
    logic [31:0]   redirect_pc;
    logic [15:0]   mispredict_count;

    modport master (
        output fetch_valid, fetch_pc,
        output resolve_valid, resolve_pc, resolve_taken, resolve_target, resolve_pred_pc, resolve_ghr,
        input  pred_pc, pred_taken, pred_ghr, flush, redirect_pc, mispredict_count
    );

    modport slave (
        input  fetch_valid, fetch_pc,
        input  resolve_valid, resolve_pc, resolve_taken, resolve_target, resolve_pred_pc, resolve_ghr,
        output pred_pc, pred_taken, pred_ghr, flush, redirect_pc, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_unit.sv
// Direct-mapped BTB plus 2-bit counter PHT (bimodal or gshare), combinational
// fetch lookup, non-speculative training and history update at resolve.
module branch_predictor_unit #(
    parameter int         ENTRIES   = 32,
    parameter int         HIST_BITS = 0,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic                     clk,
    input  logic                     reset,
    branch_predictor_unit_if.slave   bus
);
    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;
    localparam int GW   = (HIST_BITS > 0) ? HIST_BITS : 1;

    logic            btb_valid_q [ENTRIES];
    logic [TAGW-1:0] btb_tag_q   [ENTRIES];
    logic [31:0]     btb_tgt_q   [ENTRIES];
    logic [1:0]      pht_q       [ENTRIES];
    logic [GW-1:0]   ghr_q, ghr_d;
    logic [15:0]     miss_cnt_q, miss_cnt_d;

    logic [IDX-1:0]  f_idx, f_pidx, f_hist;
    logic [TAGW-1:0] f_tag;
    logic            f_hit;
    logic [IDX-1:0]  r_idx, r_pidx, r_hist;
    logic [TAGW-1:0] r_tag;
    logic [1:0]      pht_cur, pht_nxt;
    logic [31:0]     actual_next;
    logic            flush;

    generate
        if (HIST_BITS > 0) begin : g_gshare
            assign f_hist = IDX'(ghr_q);
            assign r_hist = IDX'(bus.resolve_ghr);
        end else begin : g_bimodal
            assign f_hist = '0;
            assign r_hist = '0;
        end
    endgenerate

    assign f_idx  = bus.fetch_pc[IDX+1:2];
    assign f_tag  = bus.fetch_pc[31:IDX+2];
    assign f_pidx = f_idx ^ f_hist;
    assign f_hit  = bus.fetch_valid & btb_valid_q[f_idx] & (btb_tag_q[f_idx] == f_tag);

    assign bus.pred_taken = f_hit & pht_q[f_pidx][1];
    assign bus.pred_pc    = bus.pred_taken ? btb_tgt_q[f_idx] : bus.fetch_pc + 32'd4;
    assign bus.pred_ghr   = ghr_q;

    assign r_idx  = bus.resolve_pc[IDX+1:2];
    assign r_tag  = bus.resolve_pc[31:IDX+2];
    assign r_pidx = r_idx ^ r_hist;

    assign actual_next = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 32'd4;
    // Gated by reset so a resolve presented during reset never raises a flush.
    assign flush       = bus.resolve_valid & (actual_next != bus.resolve_pred_pc) & ~reset;

    assign bus.flush            = flush;
    assign bus.redirect_pc      = actual_next;
    assign bus.mispredict_count = miss_cnt_q;

    always_comb begin
        pht_cur = pht_q[r_pidx];
        pht_nxt = pht_cur;
        if (bus.resolve_taken) begin
            if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'b01;
        end else begin
            if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'b01;
        end
    end

    always_comb begin
        ghr_d      = ghr_q;
        miss_cnt_d = miss_cnt_q;
        if (bus.resolve_valid && (HIST_BITS > 0)) ghr_d = (ghr_q << 1) | GW'(bus.resolve_taken);
        if (flush && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_q[i] <= 1'b0;
                btb_tag_q[i]   <= '0;
                btb_tgt_q[i]   <= '0;
                pht_q[i]       <= CNT_INIT;
            end
            ghr_q      <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (bus.resolve_valid) begin
                pht_q[r_pidx] <= pht_nxt;
                if (bus.resolve_taken) begin
                    btb_valid_q[r_idx] <= 1'b1;
                    btb_tag_q[r_idx]   <= r_tag;
                    btb_tgt_q[r_idx]   <= bus.resolve_target;
                end
            end
            ghr_q      <= ghr_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Word-alignment bits and, in bimodal mode, the history input carry no information.
    logic unused_bits;
    assign unused_bits = ^{bus.fetch_pc[1:0], bus.resolve_pc[1:0], bus.resolve_ghr};
endmodule

// File: tb/tb_branch_predictor_unit.sv
// Bench for branch_predictor_unit: bimodal instance (a) and 2-bit gshare instance (b)
// checked against a table model built from pc arithmetic.
module tb_branch_predictor_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    branch_predictor_unit_if #(.GW(1)) bus_a ();
    branch_predictor_unit_if #(.GW(2)) bus_b ();

    branch_predictor_unit #(.ENTRIES(32), .HIST_BITS(0), .CNT_INIT(2'b01)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    branch_predictor_unit #(.ENTRIES(32), .HIST_BITS(2), .CNT_INIT(2'b01)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    // reference model: u=0 bimodal, u=1 gshare with 2 history bits
    bit          m_valid [2][32];
    logic [31:0] m_tag   [2][32];
    logic [31:0] m_tgt   [2][32];
    int          m_pht   [2][32];
    int          m_ghr;
    int          m_cnt   [2];

    logic [31:0] o_ppc, o_ghr, o_redir, o_cnt;
    logic        o_pt, o_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[u][i] = 1'b0;
                m_tag[u][i]   = '0;
                m_tgt[u][i]   = '0;
                m_pht[u][i]   = 1;
            end
            m_cnt[u] = 0;
        end
        m_ghr = 0;
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 32);
    endfunction

    function automatic bit m_taken(input int u, input bit fv, input logic [31:0] pc);
        int i;
        int h;
        i = idx_of(pc);
        h = (u == 1) ? m_ghr : 0;
        return fv && m_valid[u][i] && (m_tag[u][i] == pc / 128) && (m_pht[u][i ^ h] >= 2);
    endfunction

    function automatic logic [31:0] m_pred(input int u, input bit fv, input logic [31:0] pc);
        return m_taken(u, fv, pc) ? m_tgt[u][idx_of(pc)] : pc + 32'd4;
    endfunction

    task automatic drive(input int u, input bit fv, input logic [31:0] fpc, input bit rv,
                         input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                         input logic [31:0] rpred, input logic [1:0] rghr);
        bus_a.fetch_valid = 1'b0; bus_a.resolve_valid = 1'b0;
        bus_b.fetch_valid = 1'b0; bus_b.resolve_valid = 1'b0;
        if (u == 0) begin
            bus_a.fetch_valid = fv; bus_a.fetch_pc = fpc; bus_a.resolve_valid = rv;
            bus_a.resolve_pc = rpc; bus_a.resolve_taken = rt; bus_a.resolve_target = rtgt;
            bus_a.resolve_pred_pc = rpred; bus_a.resolve_ghr = 1'b0;
        end else begin
            bus_b.fetch_valid = fv; bus_b.fetch_pc = fpc; bus_b.resolve_valid = rv;
            bus_b.resolve_pc = rpc; bus_b.resolve_taken = rt; bus_b.resolve_target = rtgt;
            bus_b.resolve_pred_pc = rpred; bus_b.resolve_ghr = rghr;
        end
    endtask

    task automatic sample(input int u);
        if (u == 0) begin
            o_ppc = bus_a.pred_pc; o_pt = bus_a.pred_taken; o_ghr = 32'(bus_a.pred_ghr);
            o_flush = bus_a.flush; o_redir = bus_a.redirect_pc; o_cnt = 32'(bus_a.mispredict_count);
        end else begin
            o_ppc = bus_b.pred_pc; o_pt = bus_b.pred_taken; o_ghr = 32'(bus_b.pred_ghr);
            o_flush = bus_b.flush; o_redir = bus_b.redirect_pc; o_cnt = 32'(bus_b.mispredict_count);
        end
    endtask

    // one clock cycle: drive, check combinational outputs mid-cycle, then advance the model
    task automatic step(input int u, input bit fv, input logic [31:0] fpc, input bit rv,
                        input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                        input logic [31:0] rpred, input logic [1:0] rghr);
        logic [31:0] nxt;
        bit          exp_flush;
        int          p;
        drive(u, fv, fpc, rv, rpc, rt, rtgt, rpred, rghr);
        nxt = rt ? rtgt : rpc + 32'd4;
        exp_flush = rv && (nxt != rpred);
        @(negedge clk);
        sample(u);
        chk("pred_pc", o_ppc, m_pred(u, fv, fpc));
        chk("pred_taken", 32'(o_pt), 32'(m_taken(u, fv, fpc)));
        chk("pred_ghr", o_ghr, (u == 1) ? 32'(m_ghr) : 32'd0);
        chk("flush", 32'(o_flush), 32'(exp_flush));
        if (rv) chk("redirect_pc", o_redir, nxt);
        chk("mispredict_count", o_cnt, 32'(m_cnt[u]));
        @(posedge clk);
        if (rv) begin
            p = idx_of(rpc) ^ ((u == 1) ? int'(rghr) : 0);
            if (rt) m_pht[u][p] = (m_pht[u][p] == 3) ? 3 : m_pht[u][p] + 1;
            else    m_pht[u][p] = (m_pht[u][p] == 0) ? 0 : m_pht[u][p] - 1;
            if (rt) begin
                m_valid[u][idx_of(rpc)] = 1'b1;
                m_tag[u][idx_of(rpc)]   = rpc / 128;
                m_tgt[u][idx_of(rpc)]   = rtgt;
            end
            if (u == 1) m_ghr = ((m_ghr << 1) | int'(rt)) & 3;
        end
        if (exp_flush && m_cnt[u] != 65535) m_cnt[u]++;
        #1;
    endtask

    task automatic fetch_only(input int u, input logic [31:0] fpc);
        step(u, 1'b1, fpc, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);
    endtask

    task automatic resolve(input int u, input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                           input logic [31:0] rpred, input logic [1:0] rghr);
        step(u, 1'b0, 32'h0, 1'b1, rpc, rt, rtgt, rpred, rghr);
    endtask

    initial begin
        logic [31:0] fpc, rpc, rtgt, rpred;
        bit          fv, rv, rt;
        int          u, sel;
        logic [1:0]  rghr;

        model_reset();
        // flush must stay low during reset even with a mismatching resolve present
        drive(0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 32'h104, 2'b00);
        #12;
        chk("rst_flush", 32'(bus_a.flush), 32'd0);
        chk("rst_pred_taken", 32'(bus_a.pred_taken), 32'd0);
        chk("rst_count", 32'(bus_a.mispredict_count), 32'd0);
        chk("rst_ghr_b", 32'(bus_b.pred_ghr), 32'd0);
        reset = 1'b0;

        // bimodal directed
        fetch_only(0, 32'h100);
        chk("cold_pred_pc", o_ppc, 32'h104);
        step(0, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 32'h104, 2'b00);
        chk("first_flush", 32'(o_flush), 32'd1);
        chk("first_redirect", o_redir, 32'h200);
        chk("same_cycle_no_bypass", o_ppc, 32'h104);
        fetch_only(0, 32'h100);
        chk("trained_pred_pc", o_ppc, 32'h200);
        chk("trained_count", o_cnt, 32'd1);
        fetch_only(0, 32'h180);
        chk("alias_pred_pc", o_ppc, 32'h184);
        chk("alias_taken", 32'(o_pt), 32'd0);
        resolve(0, 32'h100, 1'b1, 32'h200, 32'h200, 2'b00);
        resolve(0, 32'h100, 1'b1, 32'h200, 32'h200, 2'b00);
        resolve(0, 32'h100, 1'b0, 32'h200, 32'h200, 2'b00);
        chk("nt_flush", 32'(o_flush), 32'd1);
        chk("nt_redirect", o_redir, 32'h104);
        fetch_only(0, 32'h100);
        chk("hyst_pred_pc", o_ppc, 32'h200);
        chk("hyst_count", o_cnt, 32'd2);
        step(0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 2'b00);
        chk("fetch_invalid_pc", o_ppc, 32'h104);

        // asynchronous reset between edges, with a pending taken resolve to another entry
        drive(0, 1'b1, 32'h100, 1'b1, 32'h180, 1'b1, 32'h300, 32'h184, 2'b00);
        #1;
        chk("pre_reset_taken", 32'(bus_a.pred_taken), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_taken", 32'(bus_a.pred_taken), 32'd0);
        chk("async_reset_count", 32'(bus_a.mispredict_count), 32'd0);
        chk("async_reset_flush", 32'(bus_a.flush), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        fetch_only(0, 32'h180);
        chk("discarded_update", o_ppc, 32'h184);

        // gshare directed: history 00 and 11 train PHT entries 0 and 3 separately
        resolve(1, 32'h100, 1'b1, 32'h200, 32'h104, 2'b00);
        fetch_only(1, 32'h100);
        chk("gs_hist01_pc", o_ppc, 32'h104);
        chk("gs_ghr01", o_ghr, 32'd1);
        resolve(1, 32'h100, 1'b1, 32'h200, 32'h200, 2'b11);
        fetch_only(1, 32'h100);
        chk("gs_hist11_pc", o_ppc, 32'h200);
        resolve(1, 32'h100, 1'b0, 32'h200, 32'h200, 2'b11);
        resolve(1, 32'h100, 1'b0, 32'h200, 32'h104, 2'b01);
        resolve(1, 32'h100, 1'b0, 32'h200, 32'h104, 2'b01);
        fetch_only(1, 32'h100);
        chk("gs_hist00_pc", o_ppc, 32'h200);
        chk("gs_count", o_cnt, 32'd2);

        // randomized traffic on both instances over a small pc set to force hits and aliases
        for (int i = 0; i < 400; i++) begin
            u    = $urandom_range(0, 1);
            fv   = ($urandom_range(0, 3) != 0);
            fpc  = 32'h1000 | (32'($urandom_range(0, 1)) << 7) | (32'($urandom_range(0, 7)) << 2);
            rv   = $urandom_range(0, 1);
            rt   = $urandom_range(0, 1);
            rpc  = 32'h1000 | (32'($urandom_range(0, 1)) << 7) | (32'($urandom_range(0, 7)) << 2);
            rtgt = 32'h4000 + (32'($urandom_range(0, 15)) << 2);
            rghr = 2'($urandom_range(0, 3));
            if (u == 1 && $urandom_range(0, 1) == 1) rghr = 2'(m_ghr);
            sel  = $urandom_range(0, 2);
            if (sel == 0)      rpred = m_pred(u, 1'b1, rpc);
            else if (sel == 1) rpred = rpc + 32'd4;
            else               rpred = rtgt;
            step(u, fv, fpc, rv, rpc, rt, rtgt, rpred, rghr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor_unit.md
BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

Parameters
REQ-001 SHALL provide ENTRIES, default 32, BTB/PHT depth; power of two, 4..1024; IDX = log2(ENTRIES).
REQ-002 SHALL provide HIST_BITS, default 0, global history length; 0 = bimodal, 1..IDX = gshare.
REQ-003 SHALL provide CNT_INIT, default 2'b01, counter reset value (weakly not-taken).

Interface
REQ-004 clk  in  1  rising-edge clock; one clock, no other clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 fetch_valid  in  1  fetch-stage lookup request.
REQ-007 fetch_pc  in  32  fetch address.
REQ-008 pred_pc  out  32  predicted next PC.
REQ-009 pred_taken  out  1  prediction is taken.
REQ-010 pred_ghr  out  max(HIST_BITS,1)  history snapshot; carried down the pipe.
REQ-011 resolve_valid  in  1  a jump/branch resolved in EX this cycle.
REQ-012 resolve_pc  in  32  PC of the resolved instruction.
REQ-013 resolve_taken  in  1  actual direction (1 for jumps).
REQ-014 resolve_target  in  32  computed target.
REQ-015 resolve_pred_pc  in  32  pred_pc issued for this instruction at fetch.
REQ-016 resolve_ghr  in  max(HIST_BITS,1)  pred_ghr issued at fetch.
REQ-017 flush  out  1  misprediction; squash younger instructions.
REQ-018 redirect_pc  out  32  correct next PC; valid when flush=1.
REQ-019 mispredict_count  out  16  saturating misprediction counter.

Function
REQ-020 Index = pc[IDX+1:2]; tag = pc[31:IDX+2]; BTB entry = {valid, tag, target[31:0]}.
REQ-021 PHT index = BTB index when HIST_BITS=0; otherwise BTB index XOR zero-extended history.
REQ-022 Lookup SHALL be combinational; hit = fetch_valid & valid & tag match.
REQ-023 pred_taken = hit & PHT[idx][1]; pred_pc = pred_taken ? stored target : fetch_pc+4 (mod 2^32).
REQ-024 pred_ghr SHALL equal the current GHR; it SHALL be constant 0 when HIST_BITS=0.
REQ-025 actual_next = resolve_taken ? resolve_target : resolve_pc+4.
REQ-026 flush = resolve_valid & (actual_next != resolve_pred_pc), combinational.
REQ-027 redirect_pc SHALL equal actual_next.
REQ-028 On clk edge with resolve_valid, PHT[idx(resolve_pc, resolve_ghr)] SHALL saturating-increment if taken, else saturating-decrement; 11 and 00 hold.
REQ-029 On clk edge with resolve_valid & resolve_taken, the BTB entry SHALL be written: valid=1, tag and target from resolve inputs.
REQ-030 Not-taken resolves SHALL NOT write the BTB.
REQ-031 On clk edge with resolve_valid and HIST_BITS>0, GHR <= {GHR[HIST_BITS-2:0], resolve_taken}; GHR updates non-speculatively at resolve only.
REQ-032 On clk edge with flush, mispredict_count SHALL increment and saturate at 16'hFFFF.
REQ-033 Fetch and resolve to the same entry in one cycle: fetch SHALL see pre-update contents; no bypass.
REQ-034 Tag mismatch on a valid entry (alias) SHALL predict fetch_pc+4; a later taken resolve SHALL overwrite the entry.
REQ-035 fetch_valid=0 SHALL force pred_taken=0 and pred_pc=fetch_pc+4.

Reset
REQ-036 While reset=1, all valid bits, GHR and mispredict_count SHALL be 0, all PHT counters SHALL be CNT_INIT, pred_taken=0, and flush=0.
REQ-037 Reset asserted mid-operation SHALL clear state immediately, without a clock edge; any pending update SHALL be discarded.

Verification
REQ-038 Reset, fetch 0x100 -> pred_pc=0x104, pred_taken=0, mispredict_count=0.
REQ-039 Resolve pc=0x100, taken, target=0x200, pred_pc=0x104 -> flush=1, redirect_pc=0x200; next cycle count=1, fetch 0x100 -> pred_pc=0x200, taken=1.
REQ-040 Fetch 0x180 after REQ-039 (same index, tag differs) -> pred_pc=0x184, pred_taken=0.
REQ-041 Two more taken resolves of 0x100 (counter 11), then not-taken with pred_pc=0x200 -> flush=1, redirect_pc=0x104; counter=10, fetch 0x100 still predicts 0x200.
REQ-042 Reset asserted between edges with an entry valid -> pred_taken falls to 0 combinationally, count=0.
REQ-043 HIST_BITS=2: taken resolves of 0x100 with ghr 00 and ghr 11 -> separate PHT entries (idx 0 and 3) train independently.
